// File: rtl/mul_pkg.sv
// Shared types and constants for the signed-digit multiplier front end.
// Digits are {plus,minus} pairs packed NUM_BITS per RAM word.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PAD,
      FIN
   } state_t;

   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_NEG  = 2'b01;

   localparam int NUM_BITS = 4;
   localparam int CNT_W    = 9;
   localparam int ADDR_W   = 7;

   function automatic logic [1:0] clean_digit(input logic [1:0] d);
      return (d == 2'b11) ? DIG_ZERO : d;
   endfunction

endpackage

// File: rtl/mul_digit_sequencer.sv
// Accepts a session of digit pairs and streams them, one write per
// cycle, to the RAM packing stage; pads the final word with zeros.
module mul_digit_sequencer
   import mul_pkg::*;
#(
   parameter int NUM_BITS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  last_idx,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        x_digit,
   input  logic [1:0]        y_digit,
   output logic [1:0]        x_input,
   output logic [1:0]        y_input,
   output logic [CNT_W-1:0]  cnt,
   output logic [ADDR_W-1:0] computation_cycles,
   output logic              we,
   output logic              write_enable,
   output logic              busy,
   output logic              done,
   output logic              illegal_digit
);

   localparam logic [1:0] SLOT_LAST = 2'(NUM_BITS - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] last_q, last_n;
   logic [CNT_W-1:0] idx_q, idx_n;
   logic [CNT_W-1:0] cnt_n;
   logic [1:0]       x_n, y_n;
   logic             we_n, busy_n, done_n, ill_n;
   logic             fire;

   assign in_ready           = (state == LOAD);
   assign fire               = in_valid && in_ready;
   assign computation_cycles = cnt[CNT_W-1:2];

   always_comb begin
      state_n = state;
      last_n  = last_q;
      idx_n   = idx_q;
      cnt_n   = cnt;
      x_n     = x_input;
      y_n     = y_input;
      we_n    = 1'b0;
      busy_n  = busy;
      done_n  = 1'b0;
      ill_n   = illegal_digit;
      unique case (state)
         IDLE: begin
            if (start) begin
               last_n  = last_idx;
               idx_n   = '0;
               ill_n   = 1'b0;
               busy_n  = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: begin
            if (fire) begin
               x_n   = clean_digit(x_digit);
               y_n   = clean_digit(y_digit);
               cnt_n = idx_q;
               idx_n = idx_q + 1'b1;
               we_n  = 1'b1;
               if (x_digit == 2'b11 || y_digit == 2'b11)
                  ill_n = 1'b1;
               // idx_q may wrap after 511, but LOAD is left first
               if (idx_q == last_q)
                  state_n = (last_q[1:0] == SLOT_LAST) ? FIN : PAD;
            end
         end
         PAD: begin
            x_n   = DIG_ZERO;
            y_n   = DIG_ZERO;
            cnt_n = cnt + 1'b1;
            we_n  = 1'b1;
            if (cnt_n[1:0] == SLOT_LAST)
               state_n = FIN;
         end
         FIN: begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_q        <= '0;
         idx_q         <= '0;
         cnt           <= '0;
         x_input       <= DIG_ZERO;
         y_input       <= DIG_ZERO;
         we            <= 1'b0;
         write_enable  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         illegal_digit <= 1'b0;
      end else begin
         state         <= state_n;
         last_q        <= last_n;
         idx_q         <= idx_n;
         cnt           <= cnt_n;
         x_input       <= x_n;
         y_input       <= y_n;
         we            <= we_n;
         write_enable  <= busy_n;
         busy          <= busy_n;
         done          <= done_n;
         illegal_digit <= ill_n;
      end
   end

endmodule

// File: tb/tb_mul_digit_sequencer.sv
// Directed sessions driven into the sequencer; expected writes are
// queued by the driver and checked by a negedge monitor.
module tb_mul_digit_sequencer;
   import mul_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] last_idx = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] x_digit = '0;
   logic [1:0] y_digit = '0;
   logic [1:0] x_input, y_input;
   logic [8:0] cnt;
   logic [6:0] computation_cycles;
   logic       we, write_enable, busy, done, illegal_digit;

   mul_digit_sequencer #(.NUM_BITS(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .last_idx(last_idx),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .x_digit(x_digit),
      .y_digit(y_digit),
      .x_input(x_input),
      .y_input(y_input),
      .cnt(cnt),
      .computation_cycles(computation_cycles),
      .we(we),
      .write_enable(write_enable),
      .busy(busy),
      .done(done),
      .illegal_digit(illegal_digit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] x;
      logic [1:0] y;
      int         cnt;
   } wr_t;

   wr_t exp_q[$];

   logic [1:0] xt[8] = '{DIG_POS, DIG_NEG, DIG_ZERO, DIG_POS,
                         DIG_POS, DIG_NEG, DIG_ZERO, DIG_NEG};
   logic [1:0] yt[8] = '{DIG_NEG, DIG_POS, DIG_POS, DIG_ZERO,
                         DIG_NEG, DIG_ZERO, DIG_POS, DIG_POS};

   int cyc = 0;
   int checks = 0;
   int passed = 0;
   int start_cyc = 0;
   int we_count = 0;
   int first_we_rel = -1;
   int last_we_rel = -1;
   int done_rel = -1;
   int done_total = 0;
   int last_cnt = 0;
   bit done_seen = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (we) begin
         we_count++;
         if (first_we_rel < 0) first_we_rel = cyc - start_cyc;
         last_we_rel = cyc - start_cyc;
         last_cnt = int'(cnt);
         if (exp_q.size() == 0) begin
            check("unexpected_we", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("x_input", int'(x_input), int'(e.x));
            check("y_input", int'(y_input), int'(e.y));
            check("cnt", int'(cnt), e.cnt);
            check("computation_cycles", int'(computation_cycles), e.cnt / 4);
            check("busy_we_high", int'({busy, write_enable}), 3);
         end
      end else if (busy && we_count > 0) begin
         check("cnt_hold", int'(cnt), last_cnt);
      end
      if (done) begin
         done_total++;
         done_seen = 1'b1;
         done_rel = cyc - start_cyc;
         check("done_we_low", int'(we), 0);
         check("done_busy_low", int'({busy, write_enable}), 0);
      end
   end

   function automatic logic [1:0] xd(input int k, input int bad);
      return (k == bad) ? 2'b11 : xt[k % 8];
   endfunction

   task automatic push_wr(input logic [1:0] x, input logic [1:0] y,
                          input int c);
      wr_t e;
      e.x = x;
      e.y = y;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string name);
      check(name, int'({in_ready, x_input, y_input, cnt,
                        computation_cycles, we, write_enable,
                        busy, done, illegal_digit}), 0);
   endtask

   // exp_done < 0 skips the fixed-latency checks
   task automatic session(input int last, input bit toggle, input int bad,
                          input int abort_at, input int busy_start_at,
                          input int exp_done, input int exp_last_we,
                          input bit exp_ill);
      int  k = 0;
      bit  v = 1'b1;
      bit  fin = 1'b0;
      int  iter = 0;
      int  dt;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      we_count = 0;
      first_we_rel = -1;
      last_we_rel = -1;
      done_seen = 1'b0;
      start = 1'b1;
      last_idx = 9'(last);
      in_valid = 1'b1;
      x_digit = xd(0, bad);
      y_digit = yt[0];
      while (!fin && iter < 2000) begin
         iter++;
         @(negedge clk);
         if (in_valid && in_ready) begin
            push_wr(xd(k, bad) == 2'b11 ? DIG_ZERO : xd(k, bad),
                    yt[k % 8], k);
            if (k == last) begin
               for (int i = last + 1; i <= (last | 3); i++)
                  push_wr(DIG_ZERO, DIG_ZERO, i);
               fin = 1'b1;
            end
            k++;
         end
         @(posedge clk);
         #1;
         if (cyc - start_cyc == 1) begin
            check("illegal_cleared", int'(illegal_digit), 0);
            check("busy_after_start",
                  int'({busy, write_enable, in_ready}), 7);
         end
         start = (k == busy_start_at) ? 1'b1 : 1'b0;
         last_idx = 9'(k);
         if (toggle) v = ~v;
         in_valid = fin ? 1'b0 : v;
         x_digit = xd(k, bad);
         y_digit = yt[k % 8];
         if (abort_at >= 0 && k == abort_at + 1) begin
            in_valid = 1'b0;
            dt = done_total;
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_all_zero("reset_mid_session");
            check("reset_queue_drained", exp_q.size(), 0);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            check("no_done_after_abort", done_total, dt);
            return;
         end
      end
      if (!fin) check("load_timeout", 0, 1);
      in_valid = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 40 && !done_seen; i++) @(posedge clk);
      check("done_seen", int'(done_seen), 1);
      @(posedge clk);
      #1;
      check("we_count", we_count, (last | 3) + 1);
      check("queue_empty", exp_q.size(), 0);
      check("illegal_sticky", int'(illegal_digit), int'(exp_ill));
      if (exp_done >= 0) begin
         check("first_we_cycle", first_we_rel, 2);
         check("last_we_cycle", last_we_rel, exp_last_we);
         check("done_cycle", done_rel, exp_done);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got %0d expected 0", 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      rst_n = 1'b1;
      session(5, 0, -1, -1, -1, 10, 9, 0);
      session(3, 0, -1, -1, -1, 6, 5, 0);
      session(6, 1, -1, -1, -1, -1, 0, 0);
      session(3, 0, 2, -1, -1, 6, 5, 1);
      session(20, 0, -1, 9, -1, -1, 0, 0);
      session(3, 0, -1, -1, -1, 6, 5, 0);
      session(511, 0, -1, -1, 100, 514, 513, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mul_digit_sequencer.md
MUL_DIGIT_SEQUENCER -- requirements
Module: mul_digit_sequencer

Interface
REQ-001 SHALL have parameter: NUM_BITS, 4, signed digits packed per RAM word; only 4 is supported.
REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  session start pulse.
- last_idx  in  9  index of final digit in session (count-1).
- in_valid  in  1  digit pair offered.
- in_ready  out  1  digit pair accepted when high with in_valid.
- x_digit, y_digit  in  2 each  {plus,minus}: 10=+1, 01=-1, 00=0, 11 illegal.
- x_input, y_input  out  2 each  digit pair to the RAM packing stage.
- cnt  out  9  global index of the digit presented; cnt[1:0] is the slot in the word.
- computation_cycles  out  7  word address, always equal to cnt[8:2].
- we  out  1  per-digit write strobe.
- write_enable  out  1  session-level write gate.
- busy  out  1  session in progress.
- done  out  1  one-cycle completion pulse.
- illegal_digit  out  1  sticky flag: a 11 digit was seen this session.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, PAD, FIN.
REQ-004 In IDLE, start=1 SHALL capture last_idx, clear illegal_digit and enter LOAD; start outside IDLE SHALL be ignored.
REQ-005 in_ready SHALL equal (state==LOAD), decoded from state only.
REQ-006 Each LOAD handshake SHALL register, next cycle: x_input/y_input = digits, cnt = digit index (0 for first), we=1.
REQ-007 Cycles without a handshake in LOAD SHALL drive we=0, with cnt, x_input and y_input held.
REQ-008 A 11 digit on either input SHALL be written as 00 and SHALL set illegal_digit until the next accepted start.
REQ-009 Accepting index == last_idx SHALL go to PAD if last_idx[1:0]!=3, else FIN.
REQ-010 PAD SHALL issue one write per cycle with digits 00 at indices last_idx+1 up to the slot-3 index of the same word, then go to FIN.
REQ-011 FIN SHALL last one cycle with done=1 and we=0, then return to IDLE.
REQ-012 write_enable and busy SHALL be 1 from the cycle after start is accepted through the last we cycle, and 0 in FIN and IDLE.
REQ-013 Write latency SHALL be exactly 1 cycle from handshake to the we cycle; outputs SHALL be registered, except computation_cycles, which is a slice of cnt.
REQ-014 last_idx=511 SHALL complete without wrap-around; cnt SHALL never exceed 511.
REQ-015 At most one write per cycle SHALL be issued; the x/y/cnt values SHALL stay stable for the whole we cycle (the consumer samples on the negedge).

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE and drive every output to 0, including in_ready.
REQ-017 Reset mid-session SHALL abandon the session without a done pulse; partially written words SHALL be left as they are.

Structure
REQ-018 Shared package mul_pkg SHALL hold the FSM state type, the digit constants DIG_ZERO/DIG_POS/DIG_NEG, NUM_BITS=4, CNT_W=9 and ADDR_W=7.
REQ-019 SHALL be a single module with no sub-modules; it connects directly to the RAM packing stage ports of the same names.

Verification
REQ-020 Bench SHALL cover:
- last_idx=5, start at cycle 0, in_valid held high -> accepts cycles 1-6; we at cycles 2-7 (cnt 0-5); pad writes cnt 6,7 at cycles 8-9; done at cycle 10.
- last_idx=3 -> no PAD; we with cnt=3 at cycle 5, done at cycle 6, computation_cycles=0 throughout.
- in_valid toggled 1,0,1,0 -> we follows with a 1-cycle lag; cnt holds during gaps; total we count = last_idx+1.
- x_digit=11 at index 2 -> x_input=00 in that write; illegal_digit=1 until the next start.
- rst_n low during LOAD at cnt=9 -> all outputs 0 immediately, no done; a new start then restarts at cnt=0.
- last_idx=511, continuous valid -> cnt reaches 511, computation_cycles=127, done with no pad writes; start during busy has no effect.
